add_subtract_pipe: RTL and testbench

- Parametrised, pipelined unsigned/two's-complement add/subtract unit. It is the multi-bit, clocked successor of the 2-bit combinational add/subtract block.
- The carry chain is split into CHUNK-bit segments, with one register stage per segment.
- Input and output use a valid/ready handshake. Adds optional unsigned saturation and a signed-overflow flag.
- Sits in datapaths that need WIDTH-bit add/sub at full throughput without a long combinational carry path.

---
 rtl/add_subtract_pipe.sv | 142 ++++++++++++++
 tb/tb_add_subtract_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_subtract_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into CHUNK-bit segments with
// one register stage each, valid/ready on both sides, optional unsigned saturation.
module add_subtract_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             sat_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;

  // Per-stage state: operands and control skew along with the partially resolved result.
  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] bx_q  [STAGES];
  logic [WIDTH-1:0] r_q   [STAGES];
  logic             c_q   [STAGES];
  logic             sub_q [STAGES];
  logic             sat_q [STAGES];
  logic             ovf_q;

  logic             in_v   [STAGES];
  logic [WIDTH-1:0] in_a   [STAGES];
  logic [WIDTH-1:0] in_bx  [STAGES];
  logic [WIDTH-1:0] in_r   [STAGES];
  logic             in_c   [STAGES];
  logic             in_sub [STAGES];
  logic             in_sat [STAGES];

  logic             adv    [STAGES];
  logic             load   [STAGES];
  logic [WIDTH-1:0] nxt_r  [STAGES];
  logic             nxt_c  [STAGES];
  logic             nxt_ovf;

  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign in_v[k]   = valid_i;
      assign in_a[k]   = a_i;
      assign in_bx[k]  = b_i ^ {WIDTH{sub_i}};
      assign in_r[k]   = '0;
      assign in_c[k]   = sub_i;
      assign in_sub[k] = sub_i;
      assign in_sat[k] = sat_i;
    end else begin : g_next
      assign in_v[k]   = v_q[k-1];
      assign in_a[k]   = a_q[k-1];
      assign in_bx[k]  = bx_q[k-1];
      assign in_r[k]   = r_q[k-1];
      assign in_c[k]   = c_q[k-1];
      assign in_sub[k] = sub_q[k-1];
      assign in_sat[k] = sat_q[k-1];
    end
  end

  // A stage advances if it holds a beat and some later stage is empty, or the output drains.
  always_comb begin : ctrl
    logic full_above;
    full_above = 1'b1;
    for (int k = int'(LAST); k >= 0; k--) begin
      adv[k]     = v_q[k] && (!full_above || ready_i);
      load[k]    = !v_q[k] || adv[k];
      full_above = full_above && v_q[k];
    end
  end

  always_comb begin : datapath
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] r;
    logic             cout;
    sum  = '0;
    r    = '0;
    for (int k = 0; k < STAGES; k++) begin
      sum = {1'b0, in_a[k][k*CHUNK +: CHUNK]} + {1'b0, in_bx[k][k*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, in_c[k]};
      r = in_r[k];
      r[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      nxt_r[k] = r;
      nxt_c[k] = sum[CHUNK];
    end
    // Final stage: flags from the unsaturated result, then optional clamp.
    cout = sum[CHUNK] ^ in_sub[LAST];
    nxt_ovf = (in_a[LAST][WIDTH-1] == in_bx[LAST][WIDTH-1]) &&
              (r[WIDTH-1] != in_a[LAST][WIDTH-1]);
    nxt_c[LAST] = cout;
    if (in_sat[LAST] && cout) begin
      nxt_r[LAST] = in_sub[LAST] ? '0 : '1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        r_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
        sat_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k] <= in_v[k];
        end
        if (load[k] && in_v[k]) begin
          a_q[k]   <= in_a[k];
          bx_q[k]  <= in_bx[k];
          r_q[k]   <= nxt_r[k];
          c_q[k]   <= nxt_c[k];
          sub_q[k] <= in_sub[k];
          sat_q[k] <= in_sat[k];
        end
      end
      if (load[LAST] && in_v[LAST]) begin
        ovf_q <= nxt_ovf;
      end
    end
  end

  assign ready_o  = rst_ni && load[0];
  assign valid_o  = v_q[LAST];
  assign result_o = r_q[LAST];
  assign cout_o   = c_q[LAST];
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_add_subtract_pipe.sv
// Scoreboard bench for add_subtract_pipe: 8/4 directed + backpressure + reset, and
// randomized runs on 8/8 and 16/2 instances against an arithmetic reference model.
module tb_add_subtract_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        o;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  // DUT0: WIDTH=8, CHUNK=4
  logic       v0, rdy0, vo0, rdyi0, sub0, sat0, co0, ov0;
  logic [7:0] a0, b0, res0;
  // DUT1: WIDTH=8, CHUNK=8
  logic       v1, rdy1, vo1, rdyi1, sub1, sat1, co1, ov1;
  logic [7:0] a1, b1, res1;
  // DUT2: WIDTH=16, CHUNK=2
  logic        v2, rdy2, vo2, rdyi2, sub2, sat2, co2, ov2;
  logic [15:0] a2, b2, res2;

  add_subtract_pipe #(.WIDTH(8), .CHUNK(4)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v0), .ready_o(rdy0), .a_i(a0), .b_i(b0),
    .sub_i(sub0), .sat_i(sat0), .valid_o(vo0), .ready_i(rdyi0), .result_o(res0),
    .cout_o(co0), .ovf_o(ov0)
  );
  add_subtract_pipe #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .ready_o(rdy1), .a_i(a1), .b_i(b1),
    .sub_i(sub1), .sat_i(sat1), .valid_o(vo1), .ready_i(rdyi1), .result_o(res1),
    .cout_o(co1), .ovf_o(ov1)
  );
  add_subtract_pipe #(.WIDTH(16), .CHUNK(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v2), .ready_o(rdy2), .a_i(a2), .b_i(b2),
    .sub_i(sub2), .sat_i(sat2), .valid_o(vo2), .ready_i(rdyi2), .result_o(res2),
    .cout_o(co2), .ovf_o(ov2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on signed and unsigned interpretations.
  function automatic exp_t model(input int w, input int a, input int b, input bit sub,
                                 input bit sat);
    exp_t   e;
    longint m, half, full, sa, sb, sr;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    full = sub ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
    e.r  = 16'(full & m);
    e.c  = sub ? (a < b) : (full > m);
    sa   = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
    sb   = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
    sr   = sub ? sa - sb : sa + sb;
    e.o  = (sr < -half) || (sr >= half);
    if (sat && e.c) e.r = sub ? 16'h0 : 16'(m);
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  int acc0 = 0;

  task automatic send0(input logic [7:0] a, input logic [7:0] b, input bit sub, input bit sat,
                       input bit lat);
    exp_t e;
    v0 = 1'b1; a0 = a; b0 = b; sub0 = sub; sat0 = sat;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rdy0) begin
        e = model(8, int'(a), int'(b), sub, sat);
        e.acc = cyc;
        e.lat = lat;
        q0.push_back(e);
        acc0++;
        @(posedge clk); #1;
        v0 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_chk++; n_err++;
    $display("FAIL d0_accept_timeout: ready_o stayed 0 for 50 cycles, required 1");
    v0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b, input bit sub, input bit sat);
    v1 = 1'b1; a1 = a; b1 = b; sub1 = sub; sat1 = sat;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rdy1) begin
        q1.push_back(model(8, int'(a), int'(b), sub, sat));
        @(posedge clk); #1;
        v1 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_chk++; n_err++;
    $display("FAIL d1_accept_timeout: ready_o stayed 0 for 50 cycles, required 1");
    v1 = 1'b0;
  endtask

  task automatic send2(input logic [15:0] a, input logic [15:0] b, input bit sub, input bit sat);
    v2 = 1'b1; a2 = a; b2 = b; sub2 = sub; sat2 = sat;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (rdy2) begin
        q2.push_back(model(16, int'(a), int'(b), sub, sat));
        @(posedge clk); #1;
        v2 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_chk++; n_err++;
    $display("FAIL d2_accept_timeout: ready_o stayed 0 for 50 cycles, required 1");
    v2 = 1'b0;
  endtask

  // Monitors: pop on every consumed output beat; dut0 also checks hold-while-stalled.
  int         outs0 = 0;
  bit         stall0 = 1'b0;
  logic [7:0] hold_r;
  logic       hold_c, hold_o;

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst_n) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        chk("d0_stall_valid", 32'(vo0), 32'd1);
        chk("d0_stall_result", 32'(res0), 32'(hold_r));
        chk("d0_stall_cout", 32'(co0), 32'(hold_c));
        chk("d0_stall_ovf", 32'(ov0), 32'(hold_o));
      end
      if (vo0 && rdyi0) begin
        if (q0.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL d0_unexpected_beat: got result %0h, required no beat", res0);
        end else begin
          e = q0.pop_front();
          outs0++;
          chk("d0_result", 32'(res0), 32'(e.r));
          chk("d0_cout", 32'(co0), 32'(e.c));
          chk("d0_ovf", 32'(ov0), 32'(e.o));
          if (e.lat) chk("d0_latency", 32'(cyc - e.acc), 32'd2);
        end
      end
      stall0 = vo0 && !rdyi0;
      hold_r = res0; hold_c = co0; hold_o = ov0;
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && vo1 && rdyi1) begin
      if (q1.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL d1_unexpected_beat: got result %0h, required no beat", res1);
      end else begin
        e = q1.pop_front();
        chk("d1_result", 32'(res1), 32'(e.r));
        chk("d1_cout", 32'(co1), 32'(e.c));
        chk("d1_ovf", 32'(ov1), 32'(e.o));
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n && vo2 && rdyi2) begin
      if (q2.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL d2_unexpected_beat: got result %0h, required no beat", res2);
      end else begin
        e = q2.pop_front();
        chk("d2_result", 32'(res2), 32'(e.r));
        chk("d2_cout", 32'(co2), 32'(e.c));
        chk("d2_ovf", 32'(ov2), 32'(e.o));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  bit done1, done2, saw_low;
  int base_acc, base_out, acc_at_low;

  initial begin
    rst_n = 1'b0;
    v0 = 0; a0 = 0; b0 = 0; sub0 = 0; sat0 = 0; rdyi0 = 1;
    v1 = 0; a1 = 0; b1 = 0; sub1 = 0; sat1 = 0; rdyi1 = 1;
    v2 = 0; a2 = 0; b2 = 0; sub2 = 0; sat2 = 0; rdyi2 = 1;
    done1 = 0; done2 = 0; saw_low = 0; acc_at_low = -1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_o", 32'(vo0), 32'd0);
    chk("rst_result_o", 32'(res0), 32'd0);
    chk("rst_cout_o", 32'(co0), 32'd0);
    chk("rst_ovf_o", 32'(ov0), 32'd0);
    chk("rst_ready_o", 32'({rdy0, rdy1, rdy2}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_o", 32'({rdy0, rdy1, rdy2}), 32'h7);
    @(posedge clk); #1;

    // Directed arithmetic, back-to-back, latency checked
    send0(8'hC8, 8'h64, 1'b0, 1'b0, 1'b1);
    send0(8'hC8, 8'h64, 1'b0, 1'b1, 1'b1);
    send0(8'h05, 8'h0A, 1'b1, 1'b0, 1'b1);
    send0(8'h05, 8'h0A, 1'b1, 1'b1, 1'b1);
    send0(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    send0(8'h80, 8'h01, 1'b1, 1'b0, 1'b1);
    send0(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("directed_drained", 32'(q0.size()), 32'd0);

    // Streaming with a 3-cycle output stall after the first result
    base_acc = acc0;
    base_out = outs0;
    fork
      begin
        for (int i = 0; i < 6; i++) send0(8'(i + 1), 8'(2 * i), 1'b0, 1'b0, 1'b0);
      end
      begin
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (vo0) break;
        end
        @(posedge clk); #1;
        rdyi0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rdyi0 = 1'b1;
      end
      begin
        repeat (20) begin
          @(negedge clk);
          if (!rdy0 && !saw_low) begin
            saw_low = 1'b1;
            acc_at_low = acc0 - base_acc;
          end
        end
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("bp_ready_fell", 32'(saw_low), 32'd1);
    chk("bp_accepts_before_full", 32'(acc_at_low), 32'd3);
    chk("bp_all_out", 32'(outs0 - base_out), 32'd6);
    chk("bp_queue_empty", 32'(q0.size()), 32'd0);

    // Asynchronous reset with two beats in flight
    rdyi0 = 1'b0;
    send0(8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    send0(8'h33, 8'h44, 1'b1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_o", 32'(vo0), 32'd0);
    chk("midrst_result_o", 32'(res0), 32'd0);
    chk("midrst_cout_o", 32'(co0), 32'd0);
    chk("midrst_ovf_o", 32'(ov0), 32'd0);
    chk("midrst_ready_o", 32'(rdy0), 32'd0);
    q0.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    rdyi0 = 1'b1;
    @(negedge clk);
    chk("after_rst_ready_o", 32'(rdy0), 32'd1);
    chk("after_rst_valid_o", 32'(vo0), 32'd0);
    repeat (6) @(posedge clk); #1;

    // Parameter sweep: random beats with random gaps and backpressure
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
          end
          send1(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        done1 = 1'b1;
      end
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
          end
          send2(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        done2 = 1'b1;
      end
      begin
        while (!done1) begin
          @(posedge clk); #1;
          rdyi1 = ($urandom_range(3) != 0);
        end
        rdyi1 = 1'b1;
      end
      begin
        while (!done2) begin
          @(posedge clk); #1;
          rdyi2 = ($urandom_range(3) != 0);
        end
        rdyi2 = 1'b1;
      end
    join
    for (int t = 0; t < 100; t++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("sweep_w8c8_drained", 32'(q1.size()), 32'd0);
    chk("sweep_w16c2_drained", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
